// File: rtl/z80_jump_seq.sv
// z80_jump_seq: sequencer for the Z80 jump/branch family (JP nn, JP cc,nn, JP (HL), JR e,
// JR cc,e, DJNZ e). The opcode byte has already been fetched; this block fetches the operand
// bytes over a simple req/ack read port, resolves the branch, and reports the next PC plus the
// architectural T/M-cycle totals for the instruction.
//
// Parameters
//   ADDR_W      address/PC width, 8..32
//   ENABLE_REL  1: JR / JR cc / DJNZ supported, 0: those opcodes decode as illegal
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               one-cycle request, opcode/flags/b_in/pc_in/hl_in valid in that cycle
//   opcode, flags, b_in opcode byte, F register (S=7, Z=6, P/V=2, C=0), B register
//   pc_in, hl_in        address of the byte after the opcode, HL register
//   mem_req, mem_addr   operand read request, held with a stable address until mem_ack
//   mem_ack, mem_data   read acknowledge, data captured on the acknowledging edge
//   busy                high from the cycle after an accepted start through the done cycle
//   done                one-cycle completion pulse; every result below is valid only with done
//   taken, illegal      branch taken, opcode unsupported
//   pc_out              next PC
//   b_out, b_we         decremented B and its write strobe (DJNZ only)
//   tcycles, mcycles    T-cycle / M-cycle totals including M1

module z80_jump_seq #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned ENABLE_REL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        opcode,
  input  logic [7:0]        flags,
  input  logic [7:0]        b_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] hl_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic [7:0]        b_out,
  output logic              b_we,
  output logic [4:0]        tcycles,
  output logic [2:0]        mcycles
);

  localparam bit RelEn = (ENABLE_REL != 0);

  // Last INTERNAL count value; INTERNAL occupies exactly five clocks.
  localparam logic [2:0] IntLast = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StInternal,
    StFin
  } state_e;

  typedef enum logic [2:0] {
    ClsIllegal,
    ClsJp,
    ClsJpCc,
    ClsJpHl,
    ClsJr,
    ClsJrCc,
    ClsDjnz
  } cls_e;

  // Instruction class of an opcode byte.
  function automatic cls_e decode(input logic [7:0] op);
    cls_e cls;
    cls = ClsIllegal;
    if (op == 8'hC3) begin
      cls = ClsJp;
    end else if (op[7:6] == 2'b11 && op[2:0] == 3'b010) begin
      cls = ClsJpCc;
    end else if (op == 8'hE9) begin
      cls = ClsJpHl;
    end else if (RelEn) begin
      if (op == 8'h18) begin
        cls = ClsJr;
      end else if (op[7:5] == 3'b001 && op[2:0] == 3'b000) begin
        cls = ClsJrCc;
      end else if (op == 8'h10) begin
        cls = ClsDjnz;
      end
    end
    return cls;
  endfunction

  // Condition codes 0..7: NZ, Z, NC, C, PO, PE, P, M.
  function automatic logic cond_true(input logic [2:0] cc, input logic s, input logic z,
                                     input logic pv, input logic c);
    logic res;
    unique case (cc)
      3'd0:    res = ~z;
      3'd1:    res = z;
      3'd2:    res = ~c;
      3'd3:    res = c;
      3'd4:    res = ~pv;
      3'd5:    res = pv;
      3'd6:    res = ~s;
      default: res = s;
    endcase
    return res;
  endfunction

  state_e state_q, state_d;
  logic [2:0] int_cnt_q, int_cnt_d;

  cls_e              cls_q;
  logic              cond_q;
  logic [7:0]        b_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] hl_q;
  logic [7:0]        lo_q;
  logic [7:0]        hi_q;

  // Decode of the incoming request.
  cls_e       cls_in;
  logic [2:0] cc_in;
  logic       cond_in;
  logic       accept;

  assign cls_in  = decode(opcode);
  // JP cc uses bits [5:3]; JR cc only has NZ/Z/NC/C in bits [4:3].
  assign cc_in   = (opcode[7:6] == 2'b11) ? opcode[5:3] : {1'b0, opcode[4:3]};
  assign cond_in = cond_true(cc_in, flags[7], flags[6], flags[2], flags[0]);
  assign accept  = (state_q == StIdle) && start;

  logic unused_flags;
  assign unused_flags = ^{flags[5:3], flags[1]};

  // Branch resolution from the captured instruction.
  logic [7:0]        b_dec;
  logic              djnz_taken;
  logic              rel_taken;
  logic              is_jp_form;
  logic [ADDR_W-1:0] jp_target;
  logic [ADDR_W-1:0] disp;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] rel_target;

  assign b_dec      = b_q - 8'd1;
  assign djnz_taken = (b_dec != 8'd0);
  assign rel_taken  = (cls_q == ClsJr) || (cls_q == ClsJrCc && cond_q) ||
                      (cls_q == ClsDjnz && djnz_taken);
  assign is_jp_form = (cls_q == ClsJp) || (cls_q == ClsJpCc);
  assign jp_target  = ADDR_W'({hi_q, lo_q});
  assign disp       = ADDR_W'($signed(lo_q));
  assign pc_next    = pc_q + ADDR_W'(1);
  assign rel_target = pc_next + disp;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      int_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      int_cnt_q <= int_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    int_cnt_d = 3'd0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (cls_in)
            ClsJp, ClsJpCc, ClsJr, ClsJrCc, ClsDjnz: state_d = StRdLo;
            default:                                 state_d = StFin;
          endcase
        end
      end
      StRdLo: begin
        if (mem_ack) begin
          if (is_jp_form) begin
            state_d = StRdHi;
          end else if (rel_taken) begin
            state_d = StInternal;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRdHi: begin
        if (mem_ack) begin
          state_d = StFin;
        end
      end
      StInternal: begin
        if (int_cnt_q == IntLast) begin
          state_d = StFin;
        end else begin
          int_cnt_d = int_cnt_q + 3'd1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Instruction and operand capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_q  <= ClsIllegal;
      cond_q <= 1'b0;
      b_q    <= 8'd0;
      pc_q   <= '0;
      hl_q   <= '0;
      lo_q   <= 8'd0;
      hi_q   <= 8'd0;
    end else begin
      if (accept) begin
        cls_q  <= cls_in;
        cond_q <= cond_in;
        b_q    <= b_in;
        pc_q   <= pc_in;
        hl_q   <= hl_in;
      end
      if (state_q == StRdLo && mem_ack) begin
        lo_q <= mem_data;
      end
      if (state_q == StRdHi && mem_ack) begin
        hi_q <= mem_data;
      end
    end
  end

  // Outputs. Results are driven only in FIN so every result reads zero outside done.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    busy     = (state_q != StIdle);
    done     = 1'b0;
    taken    = 1'b0;
    illegal  = 1'b0;
    pc_out   = '0;
    b_out    = 8'd0;
    b_we     = 1'b0;
    tcycles  = 5'd0;
    mcycles  = 3'd0;
    unique case (state_q)
      StRdLo: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      StRdHi: begin
        mem_req  = 1'b1;
        mem_addr = pc_next;
      end
      StFin: begin
        done = 1'b1;
        unique case (cls_q)
          ClsJp: begin
            taken   = 1'b1;
            pc_out  = jp_target;
            tcycles = 5'd10;
            mcycles = 3'd3;
          end
          ClsJpCc: begin
            taken   = cond_q;
            pc_out  = cond_q ? jp_target : pc_q + ADDR_W'(2);
            tcycles = 5'd10;
            mcycles = 3'd3;
          end
          ClsJpHl: begin
            taken   = 1'b1;
            pc_out  = hl_q;
            tcycles = 5'd4;
            mcycles = 3'd1;
          end
          ClsJr: begin
            taken   = 1'b1;
            pc_out  = rel_target;
            tcycles = 5'd12;
            mcycles = 3'd3;
          end
          ClsJrCc: begin
            taken   = cond_q;
            pc_out  = cond_q ? rel_target : pc_next;
            tcycles = cond_q ? 5'd12 : 5'd7;
            mcycles = cond_q ? 3'd3 : 3'd2;
          end
          ClsDjnz: begin
            taken   = djnz_taken;
            pc_out  = djnz_taken ? rel_target : pc_next;
            b_out   = b_dec;
            b_we    = 1'b1;
            tcycles = djnz_taken ? 5'd13 : 5'd8;
            mcycles = djnz_taken ? 3'd3 : 3'd2;
          end
          default: begin
            illegal = 1'b1;
            pc_out  = pc_q;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule
